// File: rtl/vga_timing_out.sv
// vga_timing_out: raster counters, sync decode and aligned pixel/sync output pipeline.
// Define VGA_TEST_PATTERN_EN to replace draw_* with eight 180 px vertical colour bars.
module vga_timing_out #(
  parameter int unsigned H_ACTIVE = 1440,
  parameter int unsigned H_FP     = 80,
  parameter int unsigned H_SYNC   = 152,
  parameter int unsigned H_BP     = 232,
  parameter int unsigned V_ACTIVE = 900,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 25,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b1,
  parameter int unsigned PIPE_DLY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  draw_r,
  input  logic [3:0]  draw_g,
  input  logic [3:0]  draw_b,
  output logic [10:0] curr_x,
  output logic [10:0] curr_y,
  output logic [3:0]  pix_r,
  output logic [3:0]  pix_g,
  output logic [3:0]  pix_b,
  output logic        hsync,
  output logic        vsync,
  output logic        vblank_tick,
  output logic        video_on
);
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_LAST = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] HA     = 11'(H_ACTIVE);
  localparam logic [10:0] VA     = 11'(V_ACTIVE);
  localparam logic [10:0] HS_ON  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_OFF = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_ON  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_OFF = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [13:0] IDLE   = {12'h000, ~H_POL, ~V_POL};
  logic [10:0] x_q, x_d, y_q, y_d;
  logic        vbt_q, vbt_d;
  logic        hs_d, vs_d;
  logic [11:0] col_d;
  logic [13:0] stg_q [PIPE_DLY];
  always_comb begin
    x_d   = (x_q == H_LAST) ? '0 : x_q + 11'd1;
    y_d   = (x_q != H_LAST) ? y_q : (y_q == V_LAST) ? '0 : y_q + 11'd1;
    // decoding the next state lets the tick coincide with the (0, V_ACTIVE) coordinate
    vbt_d = (x_d == '0) && (y_d == VA);
    hs_d  = (x_q >= HS_ON && x_q < HS_OFF) ? H_POL : ~H_POL;
    vs_d  = (y_q >= VS_ON && y_q < VS_OFF) ? V_POL : ~V_POL;
  end
  assign video_on = (x_q < HA) && (y_q < VA);
`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar;
  assign bar   = 3'(x_q / 11'd180);
  assign col_d = video_on ? {{4{~bar[1]}}, {4{~bar[2]}}, {4{~bar[0]}}} : '0;
`else
  assign col_d = video_on ? {draw_r, draw_g, draw_b} : '0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      vbt_q <= 1'b0;
      for (int i = 0; i < PIPE_DLY; i++) stg_q[i] <= IDLE;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      vbt_q    <= vbt_d;
      stg_q[0] <= {col_d, hs_d, vs_d};
      for (int i = 1; i < PIPE_DLY; i++) stg_q[i] <= stg_q[i-1];
    end
  end
  assign {pix_r, pix_g, pix_b, hsync, vsync} = stg_q[PIPE_DLY-1];
  assign curr_x      = x_q;
  assign curr_y      = y_q;
  assign vblank_tick = vbt_q;
endmodule

// File: tb/tb_vga_timing_out.sv
// tb_vga_timing_out: scoreboard bench on a shrunken raster; model derives coordinates from elapsed cycles.
module tb_vga_timing_out;
  localparam int HA = 16, HFP = 4, HS = 6, HBP = 6, HT = HA + HFP + HS + HBP;
  localparam int VA = 10, VFP = 2, VS = 3, VBP = 3, VT = VA + VFP + VS + VBP;
  localparam bit HP = 1'b0, VP = 1'b1;
  localparam int PD = 3;
  localparam logic [13:0] INACT = {12'h000, ~HP, ~VP};
  typedef struct packed {logic [10:0] x; logic [10:0] y; logic v; logic b;} co_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] draw_r = '0, draw_g = '0, draw_b = '0;
  logic [10:0] curr_x, curr_y;
  logic [3:0] pix_r, pix_g, pix_b;
  logic hsync, vsync, vblank_tick, video_on;
  int checks = 0, failures = 0, t = 0, exp_ticks = 0, got_ticks = 0;
  logic [13:0] pq[$];
  co_t cq[$];
  vga_timing_out #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .H_POL(HP), .V_POL(VP), .PIPE_DLY(PD)) dut (
    .clk(clk), .rst(rst), .draw_r(draw_r), .draw_g(draw_g), .draw_b(draw_b),
    .curr_x(curr_x), .curr_y(curr_y), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .hsync(hsync), .vsync(vsync), .vblank_tick(vblank_tick), .video_on(video_on));
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic cyc(input bit r);
    int x, y;
    logic v;
    @(negedge clk);
    rst = r;
    {draw_r, draw_g, draw_b} = 12'($urandom);
    if (r) begin
      pq.delete();
      cq.delete();
      repeat (PD) pq.push_back(INACT);
      t = 0;
    end else begin
      x = t % HT;
      y = (t / HT) % VT;
      v = (x < HA) && (y < VA);
      if (x == 0 && y == VA) exp_ticks++;
      cq.push_back({11'(x), 11'(y), v, (x == 0 && y == VA)});
      pq.push_back({v ? {draw_r, draw_g, draw_b} : 12'h000,
                    (x >= HA + HFP && x < HA + HFP + HS) ? HP : ~HP,
                    (y >= VA + VFP && y < VA + VFP + VS) ? VP : ~VP});
      t++;
    end
  endtask
  initial begin : monitor_pins
    logic [13:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (pq.size() == PD) begin
        e = pq.pop_front();
        chk("pix_rgb", {pix_r, pix_g, pix_b}, e[13:2]);
        chk("hsync", hsync, e[1]);
        chk("vsync", vsync, e[0]);
      end
    end
  end
  initial begin : monitor_coord
    co_t c;
    forever begin
      @(negedge clk);
      #1;
      if (cq.size() > 0) begin
        c = cq.pop_front();
        chk("curr_x", curr_x, c.x);
        chk("curr_y", curr_y, c.y);
        chk("video_on", video_on, c.v);
        chk("vblank_tick", vblank_tick, c.b);
        if (vblank_tick) got_ticks++;
      end
    end
  end
  initial begin
    repeat (3) cyc(1'b1);
    repeat (2 * HT * VT + 40) cyc(1'b0);
    while (!((t % HT) == HA + HFP + 2 && ((t / HT) % VT) == VA + VFP + 1)) cyc(1'b0);
    cyc(1'b1);
    repeat (HT * VT + 17) cyc(1'b0);
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(1, 3)) cyc(1'b1);
      repeat ($urandom_range(50, 700)) cyc(1'b0);
    end
    repeat (HT * VT) cyc(1'b0);
    repeat (PD + 2) @(negedge clk);
    chk("tick_count", got_ticks, exp_ticks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
